// File: rtl/bus_dev_endpoint_if.sv
// Bus/host signal bundle for bus_dev_endpoint.
//
// Handshake rules:
//   Host TX: a packet moves when tx_valid && tx_ready are both high at a rising edge.
//   Bus TX:  pndng means D_pop holds a valid head. The bus consumes it with pop.
//            A pop while pndng is low is ignored.
//   Bus RX:  push is a one-cycle delivery with no back-pressure. The endpoint
//            either stores the packet or discards it.
//   Host RX: the head moves when rx_valid && rx_ready are both high at a rising edge.
interface bus_dev_endpoint_if #(
    parameter int unsigned pckg_sz = 16
);
    logic               tx_valid;
    logic               tx_ready;
    logic [pckg_sz-1:0] tx_data;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               rx_valid;
    logic               rx_ready;
    logic [pckg_sz-1:0] rx_data;
    logic [7:0]         rx_drop_cnt;
    logic [7:0]         rx_addr_err_cnt;
    logic               pop_uflow;

    // The device endpoint.
    modport slave (
        input  tx_valid, tx_data, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_valid, rx_data,
               rx_drop_cnt, rx_addr_err_cnt, pop_uflow
    );

    // The host and bus side that drives the endpoint.
    modport master (
        output tx_valid, tx_data, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_valid, rx_data,
               rx_drop_cnt, rx_addr_err_cnt, pop_uflow
    );
endinterface

// File: rtl/bus_dev_endpoint.sv
// bus_dev_endpoint: the device side of the shared bus.
//   The TX FIFO takes host packets and offers its head to the bus through pndng/D_pop.
//   The RX FIFO stores bus deliveries whose destination ID is this device or broadcast.
// Optional macro BUS_EP_ERR_CNT_EN builds the drop/address-error counters and the
// pop-underflow flag. Without the macro these three outputs are tied to 0.
// The interface pckg_sz must match this module's pckg_sz.
module bus_dev_endpoint #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    bus_dev_endpoint_if.slave   bus
);
    localparam int unsigned AW = $clog2(depth);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(depth);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // ---------------- TX FIFO ----------------
    logic [pckg_sz-1:0] r_tx_mem [depth];
    logic [AW-1:0]      r_tx_wr_ptr;
    logic [AW-1:0]      r_tx_rd_ptr;
    logic [AW:0]        r_tx_cnt;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_tx_wr;
    logic               w_tx_rd;

    // The flags come from the registered count only.
    // A pop in the same cycle as full does not raise tx_ready until the next cycle.
    assign w_tx_full  = (r_tx_cnt == CNT_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_wr    = bus.tx_valid && !w_tx_full;
    assign w_tx_rd    = bus.pop && !w_tx_empty;

    assign bus.tx_ready = !w_tx_full;
    assign bus.pndng    = !w_tx_empty;
    assign bus.D_pop    = r_tx_mem[r_tx_rd_ptr];

    // TX storage has no reset. Clearing the count is enough to discard the contents.
    always_ff @(posedge clk) begin
        if (w_tx_wr) r_tx_mem[r_tx_wr_ptr] <= bus.tx_data;
    end

    // TX pointers and occupancy. When a write and a pop happen together, the count holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_cnt    <= '0;
        end else begin
            if (w_tx_wr) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
            if (w_tx_rd) r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
            case ({w_tx_wr, w_tx_rd})
                2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
                2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [pckg_sz-1:0] r_rx_mem [depth];
    logic [AW-1:0]      r_rx_wr_ptr;
    logic [AW-1:0]      r_rx_rd_ptr;
    logic [AW:0]        r_rx_cnt;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic [7:0]         w_dest;
    logic               w_id_ok;
    logic               w_rx_wr;
    logic               w_rx_rd;

    assign w_rx_full  = (r_rx_cnt == CNT_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_dest     = bus.D_push[pckg_sz-1 -: 8];
    assign w_id_ok    = (w_dest == id) || (w_dest == broadcast);
    // Full comes from the registered count. A push that arrives while the FIFO is
    // full is dropped, even if the host reads in the same cycle.
    assign w_rx_wr    = bus.push && w_id_ok && !w_rx_full;
    assign w_rx_rd    = bus.rx_ready && !w_rx_empty;

    assign bus.rx_valid = !w_rx_empty;
    assign bus.rx_data  = r_rx_mem[r_rx_rd_ptr];

    // RX storage, written only for accepted packets.
    always_ff @(posedge clk) begin
        if (w_rx_wr) r_rx_mem[r_rx_wr_ptr] <= bus.D_push;
    end

    // RX pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_cnt    <= '0;
        end else begin
            if (w_rx_wr) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
            if (w_rx_rd) r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
            case ({w_rx_wr, w_rx_rd})
                2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
                2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // ---------------- Error reporting ----------------
`ifdef BUS_EP_ERR_CNT_EN
    logic [7:0] r_rx_drop_cnt;
    logic [7:0] r_rx_addr_err_cnt;
    logic       r_pop_uflow;
    logic       w_rx_drop;
    logic       w_rx_addr_err;

    // The ID check comes first. A mismatched packet counts as an address error, never as a drop.
    assign w_rx_drop     = bus.push && w_id_ok && w_rx_full;
    assign w_rx_addr_err = bus.push && !w_id_ok;

    // Saturating counters and the sticky underflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_drop_cnt     <= 8'd0;
            r_rx_addr_err_cnt <= 8'd0;
            r_pop_uflow       <= 1'b0;
        end else begin
            if (w_rx_drop && (r_rx_drop_cnt != 8'hFF))
                r_rx_drop_cnt <= r_rx_drop_cnt + 8'd1;
            if (w_rx_addr_err && (r_rx_addr_err_cnt != 8'hFF))
                r_rx_addr_err_cnt <= r_rx_addr_err_cnt + 8'd1;
            if (bus.pop && w_tx_empty)
                r_pop_uflow <= 1'b1;
        end
    end

    assign bus.rx_drop_cnt     = r_rx_drop_cnt;
    assign bus.rx_addr_err_cnt = r_rx_addr_err_cnt;
    assign bus.pop_uflow       = r_pop_uflow;
`else
    assign bus.rx_drop_cnt     = 8'd0;
    assign bus.rx_addr_err_cnt = 8'd0;
    assign bus.pop_uflow       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Directed testbench for bus_dev_endpoint (pckg_sz=16, depth=8, id=2).
// Expected packets are queued when the stimulus is issued. Monitors compare them
// on the falling edge whenever a pop or an RX read takes place.
module tb_bus_dev_endpoint;
  logic clk;
  logic reset;

  bus_dev_endpoint_if #(.pckg_sz(16)) bus ();

  bus_dev_endpoint #(
    .pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

`ifdef BUS_EP_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic [15:0] exp_tx_q[$];
  logic [15:0] exp_rx_q[$];
  int n_checks = 0;
  int n_pass = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h expected no transfer", name, act);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset && bus.pop && bus.pndng) begin
      if (exp_tx_q.size() == 0) fail_now("tx_unexpected_pop", bus.D_pop);
      else begin
        e = exp_tx_q.pop_front();
        chk("tx_D_pop", bus.D_pop, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (reset && bus.rx_ready && bus.rx_valid) begin
      if (exp_rx_q.size() == 0) fail_now("rx_unexpected_data", bus.rx_data);
      else begin
        e = exp_rx_q.pop_front();
        chk("rx_data", bus.rx_data, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host write cycle. The caller states whether the endpoint must accept it.
  task automatic host_write(input logic [15:0] d, input bit accept);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    chk("tx_ready_at_write", bus.tx_ready, accept);
    if (accept) exp_tx_q.push_back(d);
    tick();
    bus.tx_valid = 1'b0;
  endtask

  task automatic bus_push(input logic [15:0] d, input bit store);
    bus.push   = 1'b1;
    bus.D_push = d;
    if (store) exp_rx_q.push_back(d);
    tick();
    bus.push = 1'b0;
  endtask

  task automatic bus_pop();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
  endtask

  task automatic tx_drain(output int n);
    n = 0;
    while (bus.pndng && n < 20) begin
      bus.pop = 1'b1;
      tick();
      n++;
    end
    bus.pop = 1'b0;
  endtask

  task automatic rx_drain(output int n);
    n = 0;
    while (bus.rx_valid && n < 20) begin
      bus.rx_ready = 1'b1;
      tick();
      n++;
    end
    bus.rx_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset        = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.pop      = 1'b0;
    bus.push     = 1'b0;
    bus.D_push   = '0;
    bus.rx_ready = 1'b0;
    #50;
    reset = 1'b1;
    tick();

    // Reset state
    chk("rst_pndng", bus.pndng, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_drop_cnt", bus.rx_drop_cnt, 0);
    chk("rst_addr_err_cnt", bus.rx_addr_err_cnt, 0);
    chk("rst_pop_uflow", bus.pop_uflow, 0);

    // 1: two writes, then pop them in order
    chk("t1_pndng_before", bus.pndng, 0);
    host_write(16'h0511, 1'b1);
    chk("t1_pndng_after_write", bus.pndng, 1);
    host_write(16'h0522, 1'b1);
    bus_pop();
    chk("t1_pndng_mid", bus.pndng, 1);
    bus_pop();
    chk("t1_pndng_empty", bus.pndng, 0);

    // 2: fill to depth. A pop with the 9th write held lets it in one cycle later.
    for (int i = 0; i < 8; i++) host_write(16'h0500 + 16'(i), 1'b1);
    chk("t2_tx_ready_full", bus.tx_ready, 0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 16'h0509;
    bus.pop      = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("t2_tx_ready_after_pop", bus.tx_ready, 1);
    exp_tx_q.push_back(16'h0509);
    tick();
    bus.tx_valid = 1'b0;
    chk("t2_tx_ready_full_again", bus.tx_ready, 0);
    tx_drain(n);
    chk("t2_drain_count", n, 8);

    // 6: write rejected while full with a pop, then write with pop at count 4
    for (int i = 0; i < 8; i++) host_write(16'h0600 + 16'(i), 1'b1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 16'h06FF;
    bus.pop      = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.pop      = 1'b0;
    chk("t6_tx_ready_cnt7", bus.tx_ready, 1);
    for (int i = 0; i < 3; i++) bus_pop();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 16'h0640;
    bus.pop      = 1'b1;
    exp_tx_q.push_back(16'h0640);
    tick();
    bus.tx_valid = 1'b0;
    bus.pop      = 1'b0;
    tx_drain(n);
    chk("t6_drain_count", n, 4);

    // 3: ID filter
    bus_push(16'h02AA, 1'b1);
    bus_push(16'hFFBB, 1'b1);
    bus_push(16'h03CC, 1'b0);
    chk("t3_addr_err_cnt", bus.rx_addr_err_cnt, CNT_EN ? 1 : 0);
    chk("t3_drop_cnt", bus.rx_drop_cnt, 0);
    rx_drain(n);
    chk("t3_rx_count", n, 2);

    // 4: RX overflow and saturation
    for (int i = 0; i < 10; i++) bus_push(16'h0200 + 16'(i), i < 8);
    chk("t4_drop_cnt_2", bus.rx_drop_cnt, CNT_EN ? 2 : 0);
    for (int i = 0; i < 300; i++) bus_push(16'h0250, 1'b0);
    chk("t4_drop_cnt_sat", bus.rx_drop_cnt, CNT_EN ? 255 : 0);
    chk("t4_addr_err_hold", bus.rx_addr_err_cnt, CNT_EN ? 1 : 0);
    rx_drain(n);
    chk("t4_rx_count", n, 8);

    // 5: pop underflow, then asynchronous reset with data queued
    bus_pop();
    chk("t5_pop_uflow", bus.pop_uflow, CNT_EN ? 1 : 0);
    chk("t5_pndng_uflow", bus.pndng, 0);
    host_write(16'h0577, 1'b1);
    tx_drain(n);
    chk("t5_uflow_fifo_intact", n, 1);
    for (int i = 0; i < 3; i++) host_write(16'h0580 + 16'(i), 1'b1);
    bus_push(16'h0290, 1'b1);
    bus_push(16'h0291, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    exp_tx_q.delete();
    exp_rx_q.delete();
    chk("t5_async_pndng", bus.pndng, 0);
    chk("t5_async_rx_valid", bus.rx_valid, 0);
    chk("t5_async_tx_ready", bus.tx_ready, 1);
    chk("t5_async_drop_cnt", bus.rx_drop_cnt, 0);
    chk("t5_async_addr_err", bus.rx_addr_err_cnt, 0);
    chk("t5_async_uflow", bus.pop_uflow, 0);
    #3;
    reset = 1'b1;
    tick();
    host_write(16'h0533, 1'b1);
    bus_push(16'h02DD, 1'b1);
    tx_drain(n);
    chk("t5_post_reset_tx", n, 1);
    rx_drain(n);
    chk("t5_post_reset_rx", n, 1);

    // Every expected packet must have been observed
    chk("end_tx_q_empty", exp_tx_q.size(), 0);
    chk("end_rx_q_empty", exp_rx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bus_dev_endpoint.md
Name: bus_dev_endpoint

Overview:
Device-side endpoint of the shared-bus protocol driven by the bus generator/arbiter.
- TX side: buffers host packets in a TX FIFO and presents the head to the bus via pndng/D_pop; the bus consumes it with pop.
- RX side: accepts bus deliveries on push/D_push, filters them on the destination ID, and buffers them in an RX FIFO for the host.
- One instance per bus device; this is the RTL counterpart of the device FIFOs the bus bench emulates.

Parameters:
pckg_sz, 16, packet width in bits; destination ID is D[pckg_sz-1 -: 8], payload is the remaining low bits
depth, 8, entries per FIFO (TX and RX), power of two, minimum 2
id, 0, this device's 8-bit bus ID
broadcast, 8'hFF, destination ID accepted by every device

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; asserting clears all state
tx_valid  in  1  host offers tx_data
tx_ready  out  1  TX FIFO not full
tx_data  in  pckg_sz  host packet, destination ID in top 8 bits
pndng  out  1  TX FIFO non-empty (request to bus)
D_pop  out  pckg_sz  TX FIFO head (show-ahead)
pop  in  1  bus consumed D_pop this cycle
push  in  1  bus delivers D_push this cycle
D_push  in  pckg_sz  delivered packet
rx_valid  out  1  RX FIFO non-empty
rx_ready  in  1  host consumes rx_data
rx_data  out  pckg_sz  RX FIFO head (show-ahead)
rx_drop_cnt  out  8  packets dropped because the RX FIFO was full (saturating)
rx_addr_err_cnt  out  8  packets rejected on ID mismatch (saturating)
pop_uflow  out  1  sticky flag: pop seen while TX FIFO empty

Behaviour:
- Reset values: pointers and counts 0; pndng=0, tx_ready=1, rx_valid=0, both counters 0, pop_uflow=0. D_pop and rx_data are don't-care while empty. Reset mid-transfer discards both FIFO contents immediately.
- FIFO state: each FIFO has rd_ptr/wr_ptr of log2(depth) bits that wrap, plus a count of log2(depth)+1 bits. full = (count==depth); empty = (count==0). Both flags are derived from registered count.
- TX write: on tx_valid && tx_ready, write mem[wr_ptr] and increment wr_ptr.
- tx_ready = !tx_full. It is computed from registered state, so a pop in the same cycle as full does not raise tx_ready until the next cycle.
- TX pop: pndng = !tx_empty and D_pop = mem[rd_ptr]. On pop && pndng, rd_ptr increments and the next head appears the following cycle (0-cycle read latency, 1-cycle advance).
- Simultaneous TX write and pop: count is unchanged and both pointers advance.
- Write into an empty TX FIFO: pndng rises the cycle after the write.
- pop with pndng=0: ignored, FIFO unchanged, pop_uflow set to 1 until reset.
- RX accept: when push=1, dest = D_push[pckg_sz-1 -: 8].
  - dest==id or dest==broadcast, and RX FIFO not full: write the packet.
  - Accepted-ID packet with RX FIFO full: drop it; rx_drop_cnt += 1, saturating at 255.
  - Any other dest: not written; rx_addr_err_cnt += 1, saturating at 255. The ID check takes priority over the full check.
- RX read: rx_valid = !rx_empty, rx_data = head. rx_ready && rx_valid advances rd_ptr.
- Simultaneous push and RX read: both occur. When full at the start of the cycle, the push is still dropped (registered full).
- Counters hold at 255 once saturated, with no wrap. Payload bits are passed through unmodified.

Optional Feature:
BUS_EP_ERR_CNT_EN
- Defined: rx_drop_cnt, rx_addr_err_cnt and pop_uflow behave as above.
- Undefined: the counter and flag logic is not built; all three outputs are tied to 0. FIFO and filtering behaviour is otherwise identical: full-drops and ID rejects still discard packets.

Test Plan:
1. id=2. Reset low 50 ns then released; host writes 16'h0511, 16'h0522 → pndng=1 one cycle after the first write; D_pop=16'h0511. After one pop, D_pop=16'h0522. After a second pop, pndng=0.
2. depth=8. Write 9 packets back-to-back with no pop → tx_ready=0 after the 8th; the 9th is not accepted. Pop once → tx_ready=1 the cycle after; the 9th is then written.
3. id=2. push D_push=16'h02AA, then 16'hFFBB, then 16'h03CC → rx_data delivers 16'h02AA then 16'hFFBB; rx_addr_err_cnt=1; 16'h03CC never appears.
4. rx_ready=0. 10 pushes of 16'h02nn → 8 stored; rx_drop_cnt=2. Then 300 more pushes → rx_drop_cnt stays 255.
5. pop pulsed with TX FIFO empty → pop_uflow=1 and FIFO unchanged. Assert reset mid-stream (3 entries queued) → pndng=0, rx_valid=0, counters=0 immediately, with no clock edge required.
6. TX FIFO full, simultaneous tx write and pop → write rejected (tx_ready was 0), count becomes 7. Then simultaneous write and pop at count 4 → count stays 4 and order is preserved.
